// File: rtl/seq_array_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier (seq_array_mult).
// Optional build macro SEQ_MULT_EARLY_TERM_EN is consumed by the top module only.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_PROD_W = 2 * DEF_WIDTH;

    // Widest operand abs_mag can handle; instances must keep WIDTH <= MAX_WIDTH.
    localparam int MAX_WIDTH  = 64;

    // Magnitude of the low w bits of x; -2^(w-1) maps to 2^(w-1) as an unsigned w-bit value.
    function automatic logic [MAX_WIDTH-1:0] abs_mag(
        input logic [MAX_WIDTH-1:0] x,
        input int                   w,
        input logic                 signed_mode
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] top;
        logic [MAX_WIDTH-1:0] xm;
        logic                 msb;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            mask[i] = (i < w);
        end
        top = mask & ~(mask >> 1);
        xm  = x & mask;
        msb = |(xm & top);
        if (signed_mode && msb) begin
            return (~xm + 1'b1) & mask;
        end
        return xm;
    endfunction

endpackage

// File: rtl/seq_array_mult_if.sv
// Operand/result handshake bundle for seq_array_mult.
// Producer side drives the master modport, the multiplier sits on the slave modport.
interface seq_array_mult_if
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   prod;

    modport master (
        output in_valid,
        output a,
        output b,
        output signed_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  prod
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  signed_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output prod
    );

endinterface

// File: rtl/seq_array_mult_mult_step.sv
// One combinational shift-add iteration of the sequential multiplier.
// The accumulator add is 2*WIDTH wide, so no carry out of the product can be lost.
module mult_step
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_next_o,
    output logic [2*WIDTH-1:0] mcand_next_o,
    output logic [WIDTH-1:0]   mplier_next_o
);

    always_comb begin
        acc_next_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
        mcand_next_o  = mcand_i << 1;
        mplier_next_o = mplier_i >> 1;
    end

endmodule

// File: rtl/seq_array_mult.sv
// Iterative WIDTH-bit shift-add multiplier with signed/unsigned mode and valid/ready handshakes.
// Define SEQ_MULT_EARLY_TERM_EN to leave CALC as soon as the remaining multiplier bits are zero.
module seq_array_mult
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH),
    localparam int PROD_W = 2 * WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    seq_array_mult_if.slave     bus
);

    state_e              state_q, state_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic                neg_q, neg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   prod_q, prod_d;

    logic [PROD_W-1:0]   acc_next;
    logic [PROD_W-1:0]   mcand_next;
    logic [WIDTH-1:0]    mplier_next;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic                last_iter;

    assign a_mag = WIDTH'(abs_mag(MAX_WIDTH'(bus.a), WIDTH, bus.signed_mode));
    assign b_mag = WIDTH'(abs_mag(MAX_WIDTH'(bus.b), WIDTH, bus.signed_mode));

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i         (acc_q),
        .mcand_i       (mcand_q),
        .mplier_i      (mplier_q),
        .acc_next_o    (acc_next),
        .mcand_next_o  (mcand_next),
        .mplier_next_o (mplier_next)
    );

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_next == '0);
`else
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_next;
                mcand_d  = mcand_next;
                mplier_d = mplier_next;
                cnt_d    = cnt_q + 1'b1;
                // Sign is applied once on the final sum; -0 is still 0, so zero stays unsigned-clean.
                if (last_iter) begin
                    prod_d  = neg_q ? (-acc_next) : acc_next;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.prod      = prod_q;

endmodule

// File: tb/tb_seq_array_mult.sv
// Self-checking bench for seq_array_mult: scoreboard of expected products plus handshake/latency checks.
// Builds at WIDTH=16 when SEQ_MULT_EARLY_TERM_EN is defined, otherwise WIDTH=8.
module tb_seq_array_mult;
    import seq_mult_pkg::*;

`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam int WIDTH   = 16;
    localparam int NRAND   = 2000;
`else
    localparam int WIDTH   = 8;
    localparam int NRAND   = 400;
`endif
    localparam int PW      = 2 * WIDTH;
    localparam int TIMEOUT = 4 * WIDTH + 20;

    logic clk = 1'b0;
    logic rst;

    seq_array_mult_if #(.WIDTH(WIDTH)) bus ();

    seq_array_mult #(
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compCount = 0;
    int errCount  = 0;
    logic [PW-1:0] expQ[$];

    task automatic checkOutput(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        compCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product straight from the arithmetic definition, not the shift-add algorithm.
    function automatic logic [PW-1:0] refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic sm);
        logic signed [PW-1:0] sa;
        logic signed [PW-1:0] sb;
        logic        [PW-1:0] ua;
        logic        [PW-1:0] ub;
        if (sm) begin
            sa = {{WIDTH{a[WIDTH-1]}}, a};
            sb = {{WIDTH{b[WIDTH-1]}}, b};
            return PW'(sa * sb);
        end
        ua = {{WIDTH{1'b0}}, a};
        ub = {{WIDTH{1'b0}}, b};
        return PW'(ua * ub);
    endfunction

    // Clock edges counted from the accept edge (inclusive) until out_valid is seen.
    function automatic int refLatency(input logic [WIDTH-1:0] b, input logic sm);
`ifdef SEQ_MULT_EARLY_TERM_EN
        logic [WIDTH-1:0] mag;
        int n;
        mag = (sm && b[WIDTH-1]) ? (~b + 1'b1) : b;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag[i]) n = i + 1;
        end
        return ((n < 1) ? 1 : n) + 1;
`else
        logic unusedBits;
        unusedBits = ^{b, sm};
        return WIDTH + 1 + (unusedBits ? 0 : 0);
`endif
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sm, input logic [PW-1:0] exp);
        bus.a           = a;
        bus.b           = b;
        bus.signed_mode = sm;
        bus.in_valid    = 1'b1;
        expQ.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sm, input logic [PW-1:0] exp, input int holdCycles);
        int            lat;
        logic          readyLeak;
        logic          stable;
        logic [PW-1:0] want;
        applyStimulus(a, b, sm, exp);
        lat       = 1;
        readyLeak = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
            if (bus.in_ready !== 1'b0) readyLeak = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.in_ready !== 1'b0) readyLeak = 1'b1;
        checkOutput({tag, "_out_valid"}, PW'(bus.out_valid), PW'(1));
        checkOutput({tag, "_in_ready_busy"}, PW'(readyLeak), PW'(0));
        checkOutput({tag, "_latency"}, PW'(lat), PW'(refLatency(b, sm)));
        want = (expQ.size() > 0) ? expQ.pop_front() : '0;
        checkOutput({tag, "_prod"}, bus.prod, want);
        if (holdCycles > 0) begin
            stable = 1'b1;
            repeat (holdCycles) begin
                @(posedge clk);
                #1;
                if (bus.out_valid !== 1'b1 || bus.prod !== want) stable = 1'b0;
            end
            checkOutput({tag, "_hold_stable"}, PW'(stable), PW'(1));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, "_out_valid_drop"}, PW'(bus.out_valid), PW'(0));
        checkOutput({tag, "_in_ready_back"}, PW'(bus.in_ready), PW'(1));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rs;
        logic             quiet;

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", PW'(bus.in_ready), PW'(1));
        checkOutput("rst_out_valid", PW'(bus.out_valid), PW'(0));
        checkOutput("rst_prod", bus.prod, PW'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed products");
        runOp("u13x11",  WIDTH'(13),   WIDTH'(11),   1'b0, PW'(143),   0);
        runOp("s_m128sq", WIDTH'(-128), WIDTH'(-128), 1'b1, PW'(16384), 0);
        runOp("s_m3x5",  WIDTH'(-3),   WIDTH'(5),    1'b1, PW'(-15),   0);
        runOp("u255sq",  WIDTH'(255),  WIDTH'(255),  1'b0, PW'(65025), 0);
        runOp("u0x200",  WIDTH'(0),    WIDTH'(200),  1'b0, PW'(0),     0);
        runOp("s0xm3",   WIDTH'(0),    WIDTH'(-3),   1'b1, PW'(0),     0);

        $display("[TB] output backpressure");
        runOp("bp200x3", WIDTH'(200),  WIDTH'(3),    1'b0, PW'(600),   20);
        runOp("u7x6",    WIDTH'(7),    WIDTH'(6),    1'b0, PW'(42),    0);

        $display("[TB] reset during CALC");
        applyStimulus(WIDTH'(100), WIDTH'(100), 1'b0, PW'(10000));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", PW'(bus.out_valid), PW'(0));
        checkOutput("abort_prod", bus.prod, PW'(0));
        checkOutput("abort_in_ready", PW'(bus.in_ready), PW'(1));
        expQ.delete();
        #2;
        rst = 1'b0;
        quiet = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) quiet = 1'b1 & 1'b0;
        end
        checkOutput("abort_no_output", PW'(quiet), PW'(1));
        runOp("u9x9", WIDTH'(9), WIDTH'(9), 1'b0, PW'(81), 0);

`ifdef SEQ_MULT_EARLY_TERM_EN
        $display("[TB] early termination");
        runOp("et1000x3", WIDTH'(1000), WIDTH'(3), 1'b0, PW'(3000), 0);
        runOp("et_b0",    WIDTH'(1234), WIDTH'(0), 1'b0, PW'(0),    0);
`endif

        $display("[TB] random operands");
        for (int i = 0; i < NRAND; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (i % 11 == 0) rb = '0;
            if (i % 13 == 0) ra = {1'b1, {(WIDTH-1){1'b0}}};
            if (i % 17 == 0) rb = '1;
            runOp("rand", ra, rb, rs, refModel(ra, rb, rs), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
